// File: rtl/compute_cos_row.sv
// compute_cos_row
//   Streams the N DCT cosine-basis terms cos((2n+1)*k*pi/(2N)), n = 0..N-1,
//   for one frequency index k per start, using an iterative CORDIC rotation
//   per term (no real-number ROM). Terms leave through a valid/ready port.
//
// Ports
//   clk      in   1          rising-edge system clock
//   reset    in   1          asynchronous, active-low; clears all state
//   start    in   1          begin a row (only looked at while idle)
//   k        in   LN         frequency index, latched on accepted start
//   busy     out  1          accepted start .. finish pulse
//   c_valid  out  1          c_n / c_val hold a valid term
//   c_ready  in   1          consumer takes the term on c_valid && c_ready
//   c_n      out  LN         sample index n of the current term
//   c_val    out  W          signed Q2.(W-2) cosine term, +1.0 = 2^(W-2)
//   finish   out  1          one-cycle pulse after term N-1 is accepted
module compute_cos_row #(
  parameter int N    = 8,
  parameter int W    = 32,
  parameter int ITER = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [$clog2(N)-1:0]    k,
  output logic                    busy,
  output logic                    c_valid,
  input  logic                    c_ready,
  output logic [$clog2(N)-1:0]    c_n,
  output logic signed [W-1:0]     c_val,
  output logic                    finish
);

  localparam int LN = $clog2(N);
  localparam int MW = LN + 2;          // phase index modulo 4N (one full turn)
  localparam int ZW = W + 2;           // CORDIC datapath width
  localparam int IW = $clog2(ITER);    // iteration counter width

  // CORDIC gain compensation 0.6072529350 at Q2.30, rescaled to Q2.(W-2)
  localparam logic [31:0]           K32     = 32'h26DD3B6A;
  localparam logic signed [ZW-1:0]  X0      = ZW'(K32 >> (32 - W));
  localparam logic signed [W-1:0]   POS_ONE = {2'b01, {(W-2){1'b0}}};
  localparam logic signed [W-1:0]   NEG_ONE = {2'b11, {(W-2){1'b0}}};
  localparam logic signed [W-1:0]   ZERO_W  = {W{1'b0}};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ROTATE = 3'd2,
    ST_OUTPUT = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // atan(2^-i) in quarter-turn units (2^30 = pi/2), scaled down to W bits
  function automatic logic signed [ZW-1:0] atan_f(input logic [IW-1:0] i);
    logic [31:0] a;
    case (32'(i))
      32'd0:   a = 32'h20000000;
      32'd1:   a = 32'h12E4051E;
      32'd2:   a = 32'h09FB385B;
      32'd3:   a = 32'h051111D4;
      32'd4:   a = 32'h028B0D43;
      32'd5:   a = 32'h0145D7E1;
      32'd6:   a = 32'h00A2F61E;
      32'd7:   a = 32'h00517C55;
      32'd8:   a = 32'h0028BE53;
      32'd9:   a = 32'h00145F2F;
      32'd10:  a = 32'h000A2F98;
      32'd11:  a = 32'h000517CC;
      32'd12:  a = 32'h00028BE6;
      32'd13:  a = 32'h000145F3;
      32'd14:  a = 32'h0000A2FA;
      32'd15:  a = 32'h0000517D;
      32'd16:  a = 32'h000028BE;
      32'd17:  a = 32'h0000145F;
      32'd18:  a = 32'h00000A30;
      32'd19:  a = 32'h00000518;
      32'd20:  a = 32'h0000028C;
      32'd21:  a = 32'h00000146;
      32'd22:  a = 32'h000000A3;
      32'd23:  a = 32'h00000051;
      32'd24:  a = 32'h00000029;
      32'd25:  a = 32'h00000014;
      32'd26:  a = 32'h0000000A;
      32'd27:  a = 32'h00000005;
      32'd28:  a = 32'h00000003;
      32'd29:  a = 32'h00000001;
      32'd30:  a = 32'h00000001;
      default: a = 32'h00000000;
    endcase
    return ZW'(a >> (32 - W));
  endfunction

  // Clamp the wide datapath value to the signed W-bit output range
  function automatic logic signed [W-1:0] sat_f(input logic signed [ZW-1:0] v);
    logic signed [W-1:0] r;
    if ((v[ZW-1:W-1] == 3'b000) || (v[ZW-1:W-1] == 3'b111)) begin
      r = v[W-1:0];
    end else if (v[ZW-1]) begin
      r = {1'b1, {(W-1){1'b0}}};
    end else begin
      r = {1'b0, {(W-1){1'b1}}};
    end
    return r;
  endfunction

  state_t                  state_r, state_s;
  logic [LN-1:0]           k_r, n_r;
  logic signed [ZW-1:0]    x_r, y_r, z_r;
  logic [IW-1:0]           iter_r;
  logic [1:0]              q_r;
  logic                    r_zero_r;

  logic [MW-1:0]           m_s;
  logic [1:0]              q_s;
  logic [LN-1:0]           r_s;
  logic signed [ZW-1:0]    z0_s;
  logic signed [ZW-1:0]    x_sh_s, y_sh_s, atan_s;
  logic signed [ZW-1:0]    x_nx_s, y_nx_s, z_nx_s;
  logic signed [ZW-1:0]    fold_s;
  logic signed [W-1:0]     bypass_s;
  logic                    last_iter_s;

  logic                    busy_s, c_valid_s, finish_s;
  logic [LN-1:0]           c_n_s;
  logic signed [W-1:0]     c_val_s;

  assign last_iter_s = (iter_r == IW'(ITER - 1));

  // Per-term setup: phase index, quadrant, residual angle for the CORDIC
  always_comb begin
    // (2n+1)*k mod 4N: truncating the product to MW bits is the modulo
    m_s  = MW'({n_r, 1'b1}) * MW'(k_r);
    q_s  = m_s[MW-1:MW-2];
    r_s  = m_s[LN-1:0];
    z0_s = $signed(ZW'(r_s) << (W - 2 - LN));
  end

  // One CORDIC rotation step driven by the sign of the residual angle
  always_comb begin
    x_sh_s = y_r >>> iter_r;
    y_sh_s = x_r >>> iter_r;
    atan_s = atan_f(iter_r);
    if (!z_r[ZW-1]) begin
      x_nx_s = x_r - x_sh_s;
      y_nx_s = y_r + y_sh_s;
      z_nx_s = z_r - atan_s;
    end else begin
      x_nx_s = x_r + x_sh_s;
      y_nx_s = y_r - y_sh_s;
      z_nx_s = z_r + atan_s;
    end
  end

  // Quadrant fold of the final rotation, plus exact values on the axes
  always_comb begin
    fold_s   = x_nx_s;
    bypass_s = POS_ONE;
    case (q_r)
      2'd0: begin fold_s = x_nx_s;  bypass_s = POS_ONE; end
      2'd1: begin fold_s = -y_nx_s; bypass_s = ZERO_W;  end
      2'd2: begin fold_s = -x_nx_s; bypass_s = NEG_ONE; end
      2'd3: begin fold_s = y_nx_s;  bypass_s = ZERO_W;  end
      default: begin fold_s = x_nx_s; bypass_s = POS_ONE; end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_s = ST_SETUP;
        else       state_s = ST_IDLE;
      end
      ST_SETUP:  state_s = ST_ROTATE;
      ST_ROTATE: begin
        if (last_iter_s) state_s = ST_OUTPUT;
        else             state_s = ST_ROTATE;
      end
      ST_OUTPUT: begin
        if (c_ready) begin
          if (n_r == LN'(N - 1)) state_s = ST_DONE;
          else                   state_s = ST_SETUP;
        end else begin
          state_s = ST_OUTPUT;
        end
      end
      ST_DONE:   state_s = ST_IDLE;
      default:   state_s = ST_IDLE;
    endcase
  end

  // FSM output logic: next values of the registered outputs
  always_comb begin
    busy_s    = 1'b0;
    c_valid_s = 1'b0;
    finish_s  = 1'b0;
    case (state_s)
      ST_SETUP:  busy_s = 1'b1;
      ST_ROTATE: busy_s = 1'b1;
      ST_OUTPUT: begin busy_s = 1'b1; c_valid_s = 1'b1; end
      ST_DONE:   finish_s = 1'b1;
      default:   busy_s = 1'b0;
    endcase
    // The term is captured as the last rotation completes, so it is
    // already stable on the first cycle c_valid is high
    if ((state_r == ST_ROTATE) && last_iter_s) begin
      c_n_s   = n_r;
      c_val_s = r_zero_r ? bypass_s : sat_f(fold_s);
    end else begin
      c_n_s   = c_n;
      c_val_s = c_val;
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy    <= 1'b0;
      c_valid <= 1'b0;
      finish  <= 1'b0;
      c_n     <= {LN{1'b0}};
      c_val   <= ZERO_W;
    end else begin
      busy    <= busy_s;
      c_valid <= c_valid_s;
      finish  <= finish_s;
      c_n     <= c_n_s;
      c_val   <= c_val_s;
    end
  end

  // Datapath registers: row context and CORDIC state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k_r      <= {LN{1'b0}};
      n_r      <= {LN{1'b0}};
      x_r      <= {ZW{1'b0}};
      y_r      <= {ZW{1'b0}};
      z_r      <= {ZW{1'b0}};
      iter_r   <= {IW{1'b0}};
      q_r      <= 2'b00;
      r_zero_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            k_r <= k;
            n_r <= {LN{1'b0}};
          end
        end
        ST_SETUP: begin
          x_r      <= X0;
          y_r      <= {ZW{1'b0}};
          z_r      <= z0_s;
          q_r      <= q_s;
          r_zero_r <= (r_s == {LN{1'b0}});
          iter_r   <= {IW{1'b0}};
        end
        ST_ROTATE: begin
          x_r    <= x_nx_s;
          y_r    <= y_nx_s;
          z_r    <= z_nx_s;
          iter_r <= iter_r + IW'(1);
        end
        ST_OUTPUT: begin
          if (c_ready) n_r <= n_r + LN'(1);
        end
        default: begin
          n_r <= n_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_compute_cos_row.sv
// tb_compute_cos_row
//   Directed bench for compute_cos_row (N=8, W=32, ITER=16). Expected terms
//   come from a real-valued cosine model pushed to a scoreboard when a row
//   is started and popped as the DUT hands each term over.
module tb_compute_cos_row;

  localparam int N    = 8;
  localparam int W    = 32;
  localparam int ITER = 16;
  localparam int LN   = 3;
  localparam longint TOL = 64'sd32768;
  localparam int ROW_BUDGET = N * (ITER + 2) + 200;

  logic                 clk = 1'b0;
  logic                 reset, start, c_ready;
  logic [LN-1:0]        k;
  logic                 busy, c_valid, finish;
  logic [LN-1:0]        c_n;
  logic signed [W-1:0]  c_val;

  int vectors     = 0;
  int miscompares = 0;

  int     exp_n_q[$];
  longint exp_v_q[$];
  bit     exact_q[$];

  compute_cos_row #(.N(N), .W(W), .ITER(ITER)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .k       (k),
    .busy    (busy),
    .c_valid (c_valid),
    .c_ready (c_ready),
    .c_n     (c_n),
    .c_val   (c_val),
    .finish  (finish)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic chk_tol(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] expv, input longint tol);
    logic signed [63:0] diff;
    diff = obs - expv;
    if (diff < 0) diff = -diff;
    vectors++;
    assert (!$isunknown(obs) && (diff <= tol)) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d (+-%0d)", tag, obs, expv, tol);
    end
  endtask

  function automatic longint ideal(input int kk, input int nn);
    real ang;
    ang = 3.14159265358979323846 * real'((2 * nn + 1) * kk) / real'(2 * N);
    return longint'($cos(ang) * real'(64'sd1 << (W - 2)));
  endfunction

  task automatic push_row(input int kk);
    for (int nn = 0; nn < N; nn++) begin
      exp_n_q.push_back(nn);
      exp_v_q.push_back(ideal(kk, nn));
      exact_q.push_back(((2 * nn + 1) * kk) % N == 0);
    end
  endtask

  task automatic consume();
    int     en;
    longint ev;
    bit     ex;
    vectors++;
    assert (exp_n_q.size() > 0) else begin
      miscompares++;
      $error("FAIL sb_underflow: observed term n=%0d expected none", c_n);
    end
    if (exp_n_q.size() > 0) begin
      en = exp_n_q.pop_front();
      ev = exp_v_q.pop_front();
      ex = exact_q.pop_front();
      chk("term_n", c_n, en);
      if (ex) chk("term_exact", c_val, ev);
      else    chk_tol("term_val", c_val, ev, TOL);
    end
  endtask

  // Runs one full row starting and ending on a falling edge.
  task automatic run_row(input int kk, input int stall_n, input int stall_cycles,
                         input int bogus_k, input bit do_bogus);
    int cyc, last_acc, nacc, extra;
    bit done, stalled;
    logic signed [W-1:0] held;
    k       = LN'(kk);
    start   = 1'b1;
    c_ready = 1'b1;
    push_row(kk);
    @(negedge clk);
    start = 1'b0;
    k     = LN'(bogus_k);
    chk("busy_after_start", busy, 1);
    cyc = 0; last_acc = -1; nacc = 0; done = 1'b0; stalled = 1'b0;
    while (!done && cyc < ROW_BUDGET) begin
      if (do_bogus && cyc == 5) start = 1'b1;
      if (do_bogus && cyc == 8) start = 1'b0;
      if (finish) begin
        done = 1'b1;
        chk("row_cycles", cyc, N * (ITER + 2) + stall_cycles);
        chk("busy_at_finish", busy, 0);
        chk("finish_after_last", cyc - last_acc, 1);
        chk("sb_drained", exp_n_q.size(), 0);
      end else begin
        if (c_valid && !stalled && stall_cycles > 0 && c_n == stall_n) begin
          c_ready = 1'b0;
          held    = c_val;
          stalled = 1'b1;
          repeat (stall_cycles) begin
            @(negedge clk);
            cyc++;
            chk("stall_valid", c_valid, 1);
            chk("stall_n", c_n, stall_n);
            chk("stall_hold", c_val, held);
            chk("stall_busy", busy, 1);
          end
          c_ready  = 1'b1;
          last_acc = -1;
        end
        if (c_valid && c_ready) begin
          consume();
          if (last_acc >= 0)                chk("accept_spacing", cyc - last_acc, ITER + 2);
          else if (nacc == 0 && !stalled)   chk("first_latency", cyc, ITER + 1);
          last_acc = cyc;
          nacc++;
        end
        @(negedge clk);
        cyc++;
      end
    end
    chk("row_finished", done, 1);
    @(negedge clk);
    chk("finish_width", finish, 0);
    chk("busy_after_row", busy, 0);
    chk("valid_after_row", c_valid, 0);
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (finish) extra++;
    end
    chk("finish_once", extra, 0);
  endtask

  initial begin
    int acc, cyc;
    reset   = 1'b0;
    start   = 1'b0;
    c_ready = 1'b0;
    k       = 3'd0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", c_valid, 0);
    chk("rst_finish", finish, 0);
    chk("rst_c_n", c_n, 0);
    chk("rst_c_val", c_val, 0);
    reset = 1'b1;
    @(negedge clk);

    // k=0: every term is exactly +1.0
    run_row(0, -1, 0, 5, 1'b0);
    // k=4 with a 10-cycle stall on n=3
    run_row(4, 3, 10, 1, 1'b0);
    // k=7 with a start pulse (different k) while busy
    run_row(7, -1, 0, 2, 1'b1);

    // Reset during the rotation of n=5
    k       = 3'd3;
    start   = 1'b1;
    c_ready = 1'b1;
    push_row(3);
    @(negedge clk);
    start = 1'b0;
    acc = 0;
    cyc = 0;
    while (acc < 5 && cyc < ROW_BUDGET) begin
      if (c_valid && c_ready) begin
        consume();
        acc++;
      end
      @(negedge clk);
      cyc++;
    end
    chk("accepts_before_reset", acc, 5);
    repeat (4) @(negedge clk);
    chk("busy_mid_rotate", busy, 1);
    reset = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", c_valid, 0);
    chk("midrst_finish", finish, 0);
    chk("midrst_c_val", c_val, 0);
    exp_n_q.delete();
    exp_v_q.delete();
    exact_q.delete();
    @(negedge clk);
    chk("midrst_no_finish", finish, 0);
    reset = 1'b1;
    @(negedge clk);

    // Fresh rows after the mid-row reset restart at n=0
    run_row(2, -1, 0, 6, 1'b0);
    run_row(5, -1, 0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
